// File: rtl/uart_fifo_ex.sv
// UART with TX/RX FIFOs behind a req/ack host port; host ops complete on the accept edge.
// No stalls: writes to a full TX FIFO are dropped (err_tx_ovf), bytes arriving at a full RX FIFO are dropped (err_overrun).

// Circular buffer; an extra pointer bit separates full from empty, and a pop on empty passes push_dat through.
module uart_fifo_ex_fifo #(
   parameter int W  = 8,
   parameter int DB = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic [DB:0]  count
);
   logic [W-1:0] mem [2**DB];
   logic [DB:0]  wr_ptr, rd_ptr;
   logic         empty, full, do_push, do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = count[DB];
   assign do_pop  = pop && (!empty || push);
   assign do_push = push && (!full || pop);
   assign pop_dat = empty ? push_dat : mem[rd_ptr[DB-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DB-1:0]] <= push_dat;
   end
endmodule

module uart_fifo_ex #(
   parameter int CLOCK_DIV          = 8,
   parameter int CLOCK_COUNTER_BITS = 4,
   parameter int DATA_BITS          = 8,
   parameter int PARITY             = 0,
   parameter int STOP_BITS          = 1,
   parameter int TX_DEPTH_BITS      = 4,
   parameter int RX_DEPTH_BITS      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   tx,
   input  logic                   rx,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   input  logic                   req,
   input  logic                   nwr,
   output logic                   ack,
   input  logic                   clr_err,
   output logic                   tx_full,
   output logic                   tx_empty,
   output logic                   rx_full,
   output logic                   rx_empty,
   output logic [RX_DEPTH_BITS:0] rx_count,
   output logic                   err_frame,
   output logic                   err_parity,
   output logic                   err_overrun,
   output logic                   err_tx_ovf
);
   localparam int CB = CLOCK_COUNTER_BITS;
   localparam logic [CB-1:0] DIV_LAST  = CB'(CLOCK_DIV - 1);
   localparam logic [CB-1:0] DIV_HALF  = CB'(CLOCK_DIV / 2 - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   // host port
   logic       accept, tx_push, tx_pop, rx_push, rx_pop;
   logic [7:0] tx_head, rx_head;
   logic [TX_DEPTH_BITS:0] tx_count;
   logic       tx_fifo_empty;
   logic       frame_ev, parity_ev, overrun_ev, tx_ovf_ev;

   assign accept    = req && !ack;
   assign tx_push   = accept && !nwr && !tx_full;
   assign tx_ovf_ev = accept && !nwr && tx_full;
   assign rx_pop    = accept && nwr;

   assign tx_fifo_empty = (tx_count == '0);
   assign tx_full       = tx_count[TX_DEPTH_BITS];
   assign rx_empty      = (rx_count == '0);
   assign rx_full       = rx_count[RX_DEPTH_BITS];

   uart_fifo_ex_fifo #(.W(8), .DB(TX_DEPTH_BITS)) u_tx_fifo (
      .clk(clk), .rst(reset), .push(tx_push), .push_dat(data_in),
      .pop(tx_pop), .pop_dat(tx_head), .count(tx_count)
   );

   uart_fifo_ex_fifo #(.W(8), .DB(RX_DEPTH_BITS)) u_rx_fifo (
      .clk(clk), .rst(reset), .push(rx_push), .push_dat(rx_shift_dat()),
      .pop(rx_pop), .pop_dat(rx_head), .count(rx_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack         <= 1'b0;
         data_out    <= '0;
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_overrun <= 1'b0;
         err_tx_ovf  <= 1'b0;
      end else begin
         ack <= req;
         if (rx_pop && (!rx_empty || rx_push)) data_out <= rx_head;
         // an event in the clearing cycle wins
         err_frame   <= (err_frame   && !clr_err) || frame_ev;
         err_parity  <= (err_parity  && !clr_err) || parity_ev;
         err_overrun <= (err_overrun && !clr_err) || overrun_ev;
         err_tx_ovf  <= (err_tx_ovf  && !clr_err) || tx_ovf_ev;
      end
   end

   // transmitter
   state_t        t_state, t_state_d;
   logic [CB-1:0] t_cnt, t_cnt_d;
   logic [2:0]    t_bit, t_bit_d;
   logic [7:0]    t_sh, t_sh_d;
   logic          t_par, t_par_d, tx_d, t_load;

   assign tx_empty = tx_fifo_empty && (t_state == S_IDLE);
   assign tx_pop   = t_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t_state <= S_IDLE;
         t_cnt   <= '0;
         t_bit   <= '0;
         t_sh    <= '0;
         t_par   <= 1'b0;
         tx      <= 1'b1;
      end else begin
         t_state <= t_state_d;
         t_cnt   <= t_cnt_d;
         t_bit   <= t_bit_d;
         t_sh    <= t_sh_d;
         t_par   <= t_par_d;
         tx      <= tx_d;
      end
   end

   always_comb begin
      t_state_d = t_state;
      t_cnt_d   = t_cnt + 1'b1;
      t_bit_d   = t_bit;
      t_sh_d    = t_sh;
      t_par_d   = t_par;
      t_load    = 1'b0;
      case (t_state)
         S_IDLE: begin
            t_cnt_d = '0;
            t_load  = !tx_fifo_empty;
         end
         S_START: if (t_cnt == DIV_LAST) begin
            t_cnt_d   = '0;
            t_state_d = S_DATA;
         end
         S_DATA: if (t_cnt == DIV_LAST) begin
            t_cnt_d = '0;
            t_sh_d  = t_sh >> 1;
            if (t_bit == DATA_LAST) begin
               t_bit_d   = '0;
               t_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               t_bit_d = t_bit + 3'd1;
            end
         end
         S_PAR: if (t_cnt == DIV_LAST) begin
            t_cnt_d   = '0;
            t_state_d = S_STOP;
         end
         S_STOP: if (t_cnt == DIV_LAST) begin
            t_cnt_d = '0;
            if (t_bit == STOP_LAST) begin
               t_bit_d   = '0;
               t_state_d = S_IDLE;
               t_load    = !tx_fifo_empty;
            end else begin
               t_bit_d = t_bit + 3'd1;
            end
         end
         default: t_state_d = S_IDLE;
      endcase
      // back-to-back frames reload straight from the last stop bit
      if (t_load) begin
         t_state_d = S_START;
         t_cnt_d   = '0;
         t_bit_d   = '0;
         t_sh_d    = tx_head & DATA_MASK;
         t_par_d   = (^(tx_head & DATA_MASK)) ^ PAR_ODD;
      end
      case (t_state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = t_sh_d[0];
         S_PAR:   tx_d = t_par_d;
         default: tx_d = 1'b1;
      endcase
   end

   // receiver
   state_t        r_state, r_state_d;
   logic [CB-1:0] r_cnt, r_cnt_d;
   logic [2:0]    r_bit, r_bit_d;
   logic [7:0]    r_sh, r_sh_d;
   logic          r_par, r_par_d, par_bad;
   logic          rx_meta, rx_sync, rx_prev;

   function automatic logic [7:0] rx_shift_dat();
      return r_sh;
   endfunction

   assign par_bad = (PARITY != 0) && (((^r_sh) ^ r_par) != PAR_ODD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_par   <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         r_state <= r_state_d;
         r_cnt   <= r_cnt_d;
         r_bit   <= r_bit_d;
         r_sh    <= r_sh_d;
         r_par   <= r_par_d;
      end
   end

   always_comb begin
      r_state_d  = r_state;
      r_cnt_d    = r_cnt + 1'b1;
      r_bit_d    = r_bit;
      r_sh_d     = r_sh;
      r_par_d    = r_par;
      rx_push    = 1'b0;
      frame_ev   = 1'b0;
      parity_ev  = 1'b0;
      overrun_ev = 1'b0;
      case (r_state)
         S_IDLE: begin
            r_cnt_d = '0;
            r_bit_d = '0;
            if (rx_prev && !rx_sync) begin
               r_state_d = S_START;
               r_sh_d    = '0;
            end
         end
         // mid-bit re-check rejects short glitches
         S_START: if (r_cnt == DIV_HALF) begin
            r_cnt_d   = '0;
            r_state_d = rx_sync ? S_IDLE : S_DATA;
         end
         S_DATA: if (r_cnt == DIV_LAST) begin
            r_cnt_d        = '0;
            r_sh_d[r_bit]  = rx_sync;
            if (r_bit == DATA_LAST) begin
               r_bit_d   = '0;
               r_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               r_bit_d = r_bit + 3'd1;
            end
         end
         S_PAR: if (r_cnt == DIV_LAST) begin
            r_cnt_d   = '0;
            r_par_d   = rx_sync;
            r_state_d = S_STOP;
         end
         S_STOP: if (r_cnt == DIV_LAST) begin
            r_cnt_d   = '0;
            r_state_d = S_IDLE;
            if (!rx_sync)                 frame_ev   = 1'b1;
            else if (par_bad)             parity_ev  = 1'b1;
            else if (rx_full && !rx_pop)  overrun_ev = 1'b1;
            else                          rx_push    = 1'b1;
         end
         default: r_state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_fifo_ex.sv
// Bench for uart_fifo_ex: default instance A (loopback or driven rx) and instance B
// with 7-bit even parity and 4-entry FIFOs.
module tb_uart_fifo_ex;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       tx_a, rx_a, ack_a, tx_full_a, tx_empty_a, rx_full_a, rx_empty_a;
   logic       req_a = 1'b0, nwr_a = 1'b0, clr_a = 1'b0, loop_a = 1'b0, rxd_a = 1'b1;
   logic [7:0] din_a = '0, dout_a;
   logic [4:0] rx_count_a;
   logic       ef_a, ep_a, eo_a, et_a;
   logic [3:0] errs_a;

   logic       tx_b, rx_b, ack_b, tx_full_b, tx_empty_b, rx_full_b, rx_empty_b;
   logic       req_b = 1'b0, nwr_b = 1'b0, clr_b = 1'b0, loop_b = 1'b0, rxd_b = 1'b1;
   logic [7:0] din_b = '0, dout_b;
   logic [2:0] rx_count_b;
   logic       ef_b, ep_b, eo_b, et_b;
   logic [3:0] errs_b;

   assign rx_a   = loop_a ? tx_a : rxd_a;
   assign rx_b   = loop_b ? tx_b : rxd_b;
   assign errs_a = {ef_a, ep_a, eo_a, et_a};
   assign errs_b = {ef_b, ep_b, eo_b, et_b};

   uart_fifo_ex u_a (
      .clk(clk), .reset(rst), .tx(tx_a), .rx(rx_a), .data_in(din_a), .data_out(dout_a),
      .req(req_a), .nwr(nwr_a), .ack(ack_a), .clr_err(clr_a),
      .tx_full(tx_full_a), .tx_empty(tx_empty_a), .rx_full(rx_full_a), .rx_empty(rx_empty_a),
      .rx_count(rx_count_a), .err_frame(ef_a), .err_parity(ep_a),
      .err_overrun(eo_a), .err_tx_ovf(et_a)
   );

   uart_fifo_ex #(.CLOCK_DIV(8), .DATA_BITS(7), .PARITY(2), .TX_DEPTH_BITS(2), .RX_DEPTH_BITS(2)) u_b (
      .clk(clk), .reset(rst), .tx(tx_b), .rx(rx_b), .data_in(din_b), .data_out(dout_b),
      .req(req_b), .nwr(nwr_b), .ack(ack_b), .clr_err(clr_b),
      .tx_full(tx_full_b), .tx_empty(tx_empty_b), .rx_full(rx_full_b), .rx_empty(rx_empty_b),
      .rx_count(rx_count_b), .err_frame(ef_b), .err_parity(ep_b),
      .err_overrun(eo_b), .err_tx_ovf(et_b)
   );

   typedef struct packed {
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] sb [$];
   logic [7:0] q;
   logic [9:0] frame_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // one req pulse held for 'hold' cycles; returns data_out as seen while ack is high
   task automatic host_op(input bit b, input bit rd, input logic [7:0] d, input int hold,
                          output logic [7:0] qo);
      @(negedge clk);
      if (b) begin req_b = 1'b1; nwr_b = rd; din_b = d; end
      else   begin req_a = 1'b1; nwr_a = rd; din_a = d; end
      repeat (hold) @(negedge clk);
      check("ack_high", b ? ack_b : ack_a, 1);
      qo = b ? dout_b : dout_a;
      if (b) req_b = 1'b0; else req_a = 1'b0;
      @(negedge clk);
      check("ack_low", b ? ack_b : ack_a, 0);
   endtask

   task automatic drive_bits(input bit b, input logic [11:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (b) rxd_b = bits[i]; else rxd_a = bits[i];
         repeat (7) @(negedge clk);
      end
   endtask

   task automatic pulse_clr(input bit b);
      @(negedge clk);
      if (b) clr_b = 1'b1; else clr_a = 1'b1;
      @(negedge clk);
      if (b) clr_b = 1'b0; else clr_a = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{din: 8'h5A, exp: 8'h5A};
      tbl[1] = '{din: 8'hA5, exp: 8'hA5};
      tbl[2] = '{din: 8'h00, exp: 8'h00};
      tbl[3] = '{din: 8'hFF, exp: 8'hFF};
      tbl[4] = '{din: 8'h01, exp: 8'h01};
      tbl[5] = '{din: 8'h80, exp: 8'h80};

      // reset state
      #12;
      check("rst_tx", tx_a, 1);
      check("rst_ack", ack_a, 0);
      check("rst_dout", dout_a, 0);
      check("rst_tx_empty", tx_empty_a, 1);
      check("rst_rx_empty", rx_empty_a, 1);
      check("rst_tx_full", tx_full_a, 0);
      check("rst_rx_full", rx_full_a, 0);
      check("rst_rx_count", rx_count_a, 0);
      check("rst_errs", errs_a, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // loopback with table vectors
      loop_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         host_op(1'b0, 1'b0, tbl[i].din, 1, q);
         sb.push_back(tbl[i].exp);
      end
      for (int i = 0; i < 1200 && rx_count_a != 5'd6; i++) @(negedge clk);
      check("lb_rx_count", rx_count_a, 6);
      host_op(1'b0, 1'b1, 8'h00, 3, q);
      check("lb_read0", q, sb.pop_front());
      check("lb_one_pop_per_req", rx_count_a, 5);
      for (int i = 1; i < 6; i++) begin
         host_op(1'b0, 1'b1, 8'h00, 1, q);
         check($sformatf("lb_read%0d", i), q, sb.pop_front());
      end
      check("lb_rx_empty", rx_empty_a, 1);
      check("lb_tx_empty", tx_empty_a, 1);
      check("lb_errs", errs_a, 0);
      host_op(1'b0, 1'b1, 8'h00, 1, q);
      check("rd_empty_dout_kept", q, 8'h80);
      check("rd_empty_count", rx_count_a, 0);

      // externally driven good frame
      loop_a = 1'b0;
      drive_bits(1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
      sb.push_back(8'h3C);
      repeat (16) @(negedge clk);
      check("ext_rx_count", rx_count_a, 1);
      host_op(1'b0, 1'b1, 8'h00, 1, q);
      check("ext_read", q, sb.pop_front());

      // framing error, line held low afterwards
      drive_bits(1'b0, {2'b00, 1'b0, 8'hA5, 1'b0}, 10);
      repeat (16) @(negedge clk);
      check("frame_err", ef_a, 1);
      check("frame_rx_count", rx_count_a, 0);
      rxd_a = 1'b1;
      repeat (4) @(negedge clk);
      pulse_clr(1'b0);
      @(negedge clk);
      check("frame_clr", errs_a, 0);

      // 2-clock glitch
      @(negedge clk);
      rxd_a = 1'b0;
      repeat (2) @(negedge clk);
      rxd_a = 1'b1;
      repeat (160) @(negedge clk);
      check("glitch_rx_count", rx_count_a, 0);
      check("glitch_errs", errs_a, 0);

      // B: exact 7E1 frame shape
      loop_b = 1'b1;
      frame_exp = {1'b1, 1'b0, 7'h55, 1'b0};
      host_op(1'b1, 1'b0, 8'h55, 1, q);
      check("b_start_latency", tx_b, 0);
      for (int k = 0; k < 10; k++) begin
         int bad;
         bad = 0;
         for (int c = 0; c < 8; c++) begin
            if (tx_b !== frame_exp[k]) bad++;
            @(negedge clk);
         end
         check($sformatf("b_tx_bit%0d_bad_cycles", k), bad, 0);
      end
      for (int i = 0; i < 200 && rx_count_b != 3'd1; i++) @(negedge clk);
      host_op(1'b1, 1'b1, 8'h00, 1, q);
      check("b_loop_read", q, 8'h55);

      // B: TX overflow and RX overrun
      for (int i = 0; i < 6; i++) begin
         host_op(1'b1, 1'b0, 8'h11 + 8'(i), 1, q);
         if (i < 4) sb.push_back(8'h11 + 8'(i));
         if (i == 3) check("b_tx_not_full_4", tx_full_b, 0);
         if (i == 4) begin
            check("b_tx_full_5", tx_full_b, 1);
            check("b_no_ovf_5", et_b, 0);
         end
         if (i == 5) check("b_ovf_6", et_b, 1);
      end
      for (int i = 0; i < 1000 && !tx_empty_b; i++) @(negedge clk);
      check("b_tx_drained", tx_empty_b, 1);
      repeat (16) @(negedge clk);
      check("b_rx_full", rx_full_b, 1);
      check("b_rx_count", rx_count_b, 4);
      check("b_overrun", eo_b, 1);
      for (int i = 0; i < 4; i++) begin
         host_op(1'b1, 1'b1, 8'h00, 1, q);
         check($sformatf("b_read%0d", i), q, sb.pop_front());
      end
      check("b_rx_empty", rx_empty_b, 1);
      check("b_no_frame_parity", {ef_b, ep_b}, 0);

      // B: parity error, then a correct frame
      pulse_clr(1'b1);
      @(negedge clk);
      check("b_clr", errs_b, 0);
      loop_b = 1'b0;
      drive_bits(1'b1, {2'b00, 1'b1, 1'b0, 7'h01, 1'b0}, 10);
      repeat (16) @(negedge clk);
      check("b_parity_err", ep_b, 1);
      check("b_parity_drop", rx_count_b, 0);
      check("b_parity_no_frame", ef_b, 0);
      drive_bits(1'b1, {2'b00, 1'b1, 1'b1, 7'h01, 1'b0}, 10);
      sb.push_back(8'h01);
      repeat (16) @(negedge clk);
      check("b_good_count", rx_count_b, 1);
      host_op(1'b1, 1'b1, 8'h00, 1, q);
      check("b_good_read", q, sb.pop_front());

      // reset in the middle of a loopback frame
      loop_a = 1'b1;
      host_op(1'b0, 1'b0, 8'h00, 1, q);
      host_op(1'b0, 1'b0, 8'hFF, 1, q);
      repeat (30) @(negedge clk);
      check("mid_tx_low", tx_a, 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_tx", tx_a, 1);
      check("mid_rst_tx_empty", tx_empty_a, 1);
      check("mid_rst_rx_empty", rx_empty_a, 1);
      check("mid_rst_rx_count", rx_count_a, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("post_rst_tx", tx_a, 1);
      check("post_rst_rx_count", rx_count_a, 0);
      check("post_rst_errs", errs_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_fifo_ex.md
UART_FIFO_EX -- requirements
Module: uart_fifo_ex

Interface
REQ-001 Parameter CLOCK_DIV, default 8: clk cycles per UART bit; legal range 4..2^CLOCK_COUNTER_BITS-1.
REQ-002 Parameter CLOCK_COUNTER_BITS, default 4: width of the bit-timing counter.
REQ-003 Parameter DATA_BITS, default 8: character length; legal range 5..8.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-006 Parameter TX_DEPTH_BITS, default 4, and RX_DEPTH_BITS, default 4: each FIFO holds 2^N entries.
REQ-007 Ports (clock and reset first):
clk  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-high reset.
tx  out  1  serial output; idles high.
rx  in  1  serial input; idles high; asynchronous to clk.
data_in  in  8  write data; bits [DATA_BITS-1:0] are used.
data_out  out  8  read data; upper unused bits are 0.
req  in  1  request strobe.
nwr  in  1  request type: 0 = write to TX FIFO, 1 = read from RX FIFO.
ack  out  1  request acknowledge.
clr_err  in  1  one-cycle pulse that clears all sticky error flags.
tx_full  out  1  TX FIFO is full.
tx_empty  out  1  TX FIFO is empty and the transmitter is idle.
rx_full  out  1  RX FIFO is full.
rx_empty  out  1  RX FIFO is empty.
rx_count  out  RX_DEPTH_BITS+1  number of entries in the RX FIFO.
err_frame  out  1  sticky framing error.
err_parity  out  1  sticky parity error.
err_overrun  out  1  sticky RX overrun.
err_tx_ovf  out  1  sticky write-while-TX-full.

Function
REQ-008 Handshake: a request is accepted on the first clk edge where req=1 and ack=0; ack rises on that edge, holds while req=1, and falls on the first edge after req=0; exactly one operation per req pulse.
REQ-009 Accepted write (nwr=0) when TX FIFO is not full: push data_in; when TX FIFO is full: drop data_in, set err_tx_ovf, and still assert ack.
REQ-010 Accepted read (nwr=1) when RX FIFO is not empty: pop the head entry into data_out on the accept edge; when RX FIFO is empty: data_out unchanged, no pop, ack still asserted.
REQ-011 FIFOs are circular buffers with wrapping pointers; full and empty are distinguished by an extra pointer bit; a simultaneous RX push and host pop on a full or empty FIFO is legal and leaves the count unchanged.
REQ-012 TX state machine IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE; each state lasts CLOCK_DIV clocks per bit.
REQ-013 TX sends data LSB first, DATA_BITS data bits, and STOP_BITS stop bits (high); TX leaves IDLE in the cycle after the TX FIFO becomes non-empty and pops the entry on entering START.
REQ-014 Back-to-back transmission: the next START begins immediately after the last stop bit if the TX FIFO is non-empty, with no idle gap.
REQ-015 rx is double-flop synchronised before use.
REQ-016 RX state machine IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
REQ-017 RX start detection: a falling edge enters START; the line is re-sampled at CLOCK_DIV/2, and if it is high the state returns to IDLE with no error (glitch rejection).
REQ-018 RX samples every subsequent bit CLOCK_DIV clocks after the previous sample point; only the first stop bit is checked.
REQ-019 At the stop-bit sample: stop bit = 0 -> set err_frame and discard the byte; parity mismatch -> set err_parity and discard the byte; RX FIFO full -> set err_overrun and discard the byte; otherwise push the byte.
REQ-020 If stop=0 the receiver returns to IDLE and waits for rx to be high before detecting a new start bit.
REQ-021 Error flags are sticky until clr_err; an error event in the same cycle as clr_err leaves the flag set.
REQ-022 Odd parity: the parity bit makes the total count of ones in data plus parity odd; even parity makes it even.

Reset
REQ-023 While reset=1 (asynchronous): tx=1, ack=0, data_out=0, both FIFOs empty (tx_empty=1, rx_empty=1, tx_full=0, rx_full=0, rx_count=0), all error flags 0, both state machines IDLE, bit counters 0.
REQ-024 Reset asserted mid-frame aborts the frame immediately; tx goes high at once; any partial RX byte is discarded.
REQ-025 After reset release, the first request is accepted one clk edge later at the earliest.

Verification
REQ-026 Loopback (tx tied to rx), defaults: write 0x5A then 0xA5, wait 30 bit times -> rx_count=2, reads return 0x5A then 0xA5, then rx_empty=1, and no error flags set.
REQ-027 PARITY=2, DATA_BITS=7: write 0x55 -> tx shows start, 1010101 LSB first, parity 0, stop 1, each bit 8 clocks wide; the loopback read returns 0x55.
REQ-028 TX_DEPTH_BITS=2, tx looped back: 6 rapid writes -> tx_full=1 after the 5th write (one entry already popped), err_tx_ovf=1 after the 6th; 5 bytes are received.
REQ-029 Drive rx with a frame whose stop bit is 0 -> err_frame=1, rx_count=0; then a clr_err pulse -> err_frame=0.
REQ-030 RX_DEPTH_BITS=2, loopback, 5 bytes with no reads -> rx_full=1, err_overrun=1, and the reads return the first 4 bytes.
REQ-031 rx low pulse of 2 clocks -> no byte received and no error; reset asserted mid-transmission -> tx=1 in the same cycle and all FIFOs empty.
